// File: rtl/gups_engine.sv
// gups_engine: GUPS random-access read-modify-write update engine.
// Walks an LFSR to pick addresses and performs NUM updates on one memory port.
module gups_engine #(
    parameter int          ADDR_W = 64,
    parameter int          DATA_W = 64,
    parameter int          CNT_W  = 32,
    parameter int          STEPS  = 4,
    parameter logic [63:0] POLY   = 64'h000000000000001B
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] seed,
    input  logic [ADDR_W-1:0] range,
    input  logic [CNT_W-1:0]  num_updates,
    input  logic [1:0]        mode,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  upd_cnt,
    output logic              err_unexp
);

    localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [ADDR_W-1:0] P_TAPS = ADDR_W'(POLY);
    localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);

    localparam logic [1:0] M_INC = 2'b00;
    localparam logic [1:0] M_XOR = 2'b01;
    localparam logic [1:0] M_WO  = 2'b10;
    localparam logic [1:0] M_RO  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GEN,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_lfsr;
    logic [ADDR_W-1:0] r_range;
    logic [CNT_W-1:0]  r_num;
    logic [1:0]        r_mode;
    logic [SW-1:0]     r_step;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;

    logic [ADDR_W-1:0] w_nxt;
    logic              w_last;
    logic              w_upd_done;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_finish;

    assign w_nxt = {r_lfsr[ADDR_W-2:0], 1'b0}
                 ^ (r_lfsr[ADDR_W-1] ? P_TAPS : '0);
    assign w_last = (r_step == LAST_STEP);
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_finish = (w_cnt_inc == r_num) || abort;
    assign w_upd_done = (r_state == S_WR_REQ && mem_ready)
                     || (r_state == S_RD_WAIT && mem_rvalid
                         && r_mode == M_RO);

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign upd_cnt   = r_cnt;
    assign err_unexp = r_err;

    // State register; reset drops any outstanding request immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        mem_req     = 1'b0;
        mem_wr      = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start)
                    w_state_nxt = (num_updates == '0) ? S_DONE : S_GEN;
            end
            S_GEN: begin
                if (abort)
                    w_state_nxt = S_DONE;
                else if (w_last)
                    w_state_nxt = (r_mode == M_WO) ? S_WR_REQ : S_RD_REQ;
            end
            S_RD_REQ: begin
                mem_req = 1'b1;
                if (mem_ready) w_state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (mem_rvalid) begin
                    if (r_mode == M_RO)
                        w_state_nxt = w_finish ? S_DONE : S_GEN;
                    else
                        w_state_nxt = S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                mem_req = 1'b1;
                mem_wr  = 1'b1;
                if (mem_ready)
                    w_state_nxt = w_finish ? S_DONE : S_GEN;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand latch, LFSR walk, address/data capture, counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr  <= ADDR_W'(1);
            r_range <= '0;
            r_num   <= '0;
            r_mode  <= '0;
            r_step  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_lfsr  <= (seed == '0) ? ADDR_W'(1) : seed;
                        r_range <= range;
                        r_num   <= num_updates;
                        r_mode  <= mode;
                        r_step  <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_GEN: begin
                    r_lfsr <= w_nxt;
                    if (w_last || abort) r_step <= '0;
                    else                 r_step <= r_step + SW'(1);
                    if (w_last && !abort) begin
                        r_addr <= w_nxt & r_range;
                        if (r_mode == M_WO) r_wdata <= DATA_W'(w_nxt);
                    end
                end
                S_RD_WAIT: begin
                    if (mem_rvalid) begin
                        if (r_mode == M_INC)
                            r_wdata <= mem_rdata + DATA_W'(1);
                        else if (r_mode == M_XOR)
                            r_wdata <= mem_rdata ^ DATA_W'(r_lfsr);
                    end
                end
                default: ;
            endcase
            if (w_upd_done) r_cnt <= w_cnt_inc;
        end
    end

    // Sticky flag for read data arriving when no read is outstanding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_err <= 1'b0;
        else if (r_state == S_IDLE && start)
            r_err <= 1'b0;
        else if (mem_rvalid && r_state != S_RD_WAIT)
            r_err <= 1'b1;
    end

endmodule

// File: tb/tb_gups_engine.sv
// tb_gups_engine: randomized bench for gups_engine with a
// transaction-level reference model and a behavioural memory.
module tb_gups_engine;

    localparam int          STEPS = 4;
    localparam logic [63:0] POLY  = 64'h000000000000001B;

    logic        clk = 1'b0;
    logic        reset, start, abort;
    logic [63:0] seed, range;
    logic [31:0] num_updates;
    logic [1:0]  mode;
    logic        mem_req, mem_wr;
    logic [63:0] mem_addr, mem_wdata;
    logic        mem_ready, mem_rvalid;
    logic [63:0] mem_rdata;
    logic        busy, done;
    logic [31:0] upd_cnt;
    logic        err_unexp;

    always #5 clk = ~clk;

    gups_engine dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .seed        (seed),
        .range       (range),
        .num_updates (num_updates),
        .mode        (mode),
        .mem_req     (mem_req),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .busy        (busy),
        .done        (done),
        .upd_cnt     (upd_cnt),
        .err_unexp   (err_unexp)
    );

    typedef struct {
        bit          wr;
        logic [63:0] a;
        logic [63:0] d;
    } req_t;

    req_t        exq[$];
    logic [63:0] mem  [logic [63:0]];
    logic [63:0] mref [logic [63:0]];

    int          n_chk = 0;
    int          n_fail = 0;
    int          rd_n, wr_n, pend, lat_max, rdy_mode, wait_n, abort_at;
    bit          stray;
    logic [63:0] pend_data;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] fill(input logic [63:0] a);
        return a * 64'h9E3779B97F4A7C15 + 64'd7;
    endfunction

    function automatic logic [63:0] ref_rd(input logic [63:0] a);
        return mref.exists(a) ? mref[a] : fill(a);
    endfunction

    // Galois LFSR as polynomial multiply-by-x modulo the taps.
    function automatic logic [63:0] lstep(input logic [63:0] l);
        return (l * 64'd2) ^ (((l >> 63) != 0) ? POLY : 64'd0);
    endfunction

    task automatic clr();
        mem.delete();
        mref.delete();
    endtask

    task automatic preload(input logic [63:0] a, input logic [63:0] d);
        mem[a]  = d;
        mref[a] = d;
    endtask

    // Expected request stream for n updates.
    task automatic build(input logic [63:0] s, input logic [63:0] r,
                         input int n, input logic [1:0] m);
        logic [63:0] l, a, d;
        l = (s == 0) ? 64'd1 : s;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < STEPS; k++) l = lstep(l);
            a = l & r;
            if (m == 2'b10) begin
                exq.push_back('{1'b1, a, l});
                mref[a] = l;
            end else begin
                exq.push_back('{1'b0, a, 64'd0});
                d = ref_rd(a);
                if (m == 2'b00) d = d + 64'd1;
                else if (m == 2'b01) d = d ^ l;
                if (m != 2'b11) begin
                    exq.push_back('{1'b1, a, d});
                    mref[a] = d;
                end
            end
        end
    endtask

    // One cycle of memory behaviour, driven and checked at negedge.
    task automatic tick();
        @(negedge clk);
        if (abort_at != 0 && rd_n == abort_at) abort = 1'b1;
        mem_rvalid = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = pend_data;
            end
        end
        if (stray) begin
            mem_rvalid = 1'b1;
            mem_rdata  = '1;
            stray      = 1'b0;
        end
        if (rdy_mode == 0) begin
            mem_ready = 1'($urandom_range(1, 0));
        end else if (rdy_mode == 1) begin
            mem_ready = 1'b1;
        end else if (mem_req) begin
            mem_ready = (wait_n >= 5);
            wait_n    = mem_ready ? 0 : wait_n + 1;
        end else begin
            mem_ready = 1'b0;
            wait_n    = 0;
        end
        if (mem_req) begin
            if (exq.size() == 0) begin
                check("extra_req", 64'd1, 64'd0);
            end else begin
                check("req_wr", 64'(mem_wr), 64'(exq[0].wr));
                check("req_addr", mem_addr, exq[0].a);
                if (exq[0].wr) check("req_wdata", mem_wdata, exq[0].d);
            end
            if (mem_ready) begin
                if (exq.size() != 0) void'(exq.pop_front());
                if (mem_wr) begin
                    wr_n++;
                    mem[mem_addr] = mem_wdata;
                end else begin
                    rd_n++;
                    pend = $urandom_range(lat_max, 1);
                    pend_data = mem.exists(mem_addr) ? mem[mem_addr]
                                                     : fill(mem_addr);
                end
            end
        end
    endtask

    task automatic run(input logic [63:0] s, input logic [63:0] r,
                       input int n, input logic [1:0] m,
                       input int rm, input int lm, input int ab,
                       input bit stray_go, input bit rst_wr,
                       input int exp_lat);
        int t, n_done, n_model;
        n_model = (ab != 0) ? ab : n;
        exq.delete();
        build(s, r, n_model, m);
        rdy_mode = rm;
        lat_max  = lm;
        abort_at = 0;
        rd_n = 0;
        wr_n = 0;
        wait_n = 0;
        pend = 0;
        seed = s;
        range = r;
        num_updates = 32'(n);
        mode = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        abort_at = ab;
        seed = {$urandom, $urandom};
        range = {$urandom, $urandom};
        num_updates = $urandom;
        mode = 2'($urandom_range(3, 0));
        if (stray_go) stray = 1'b1;
        t = 1;
        n_done = 0;
        while (t < 3000) begin
            if (done) begin
                n_done++;
                break;
            end
            if (rst_wr && mem_req && mem_wr) begin
                reset = 1'b1;
                #1;
                check("rst_req", 64'(mem_req), 64'd0);
                check("rst_wr", 64'(mem_wr), 64'd0);
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_done", 64'(done), 64'd0);
                check("rst_cnt", 64'(upd_cnt), 64'd0);
                check("rst_addr", mem_addr, 64'd0);
                check("rst_wdata", mem_wdata, 64'd0);
                exq.delete();
                pend = 0;
                rdy_mode = 1;
                tick();
                reset = 1'b0;
                tick();
                return;
            end
            tick();
            t++;
        end
        check("done_seen", 64'(n_done), 64'd1);
        if (exp_lat > 0) check("done_lat", 64'(t), 64'(exp_lat));
        if (exp_lat < 0) check("done_lat_max", 64'(t <= -exp_lat), 64'd1);
        check("upd_cnt", 64'(upd_cnt), 64'(n_model));
        check("err_unexp", 64'(err_unexp), 64'(stray_go));
        check("queue_left", 64'(exq.size()), 64'd0);
        tick();
        check("done_once", 64'(done), 64'd0);
        check("busy_end", 64'(busy), 64'd0);
        abort = 1'b0;
        abort_at = 0;
    endtask

    initial begin
        logic [63:0] rs, rr;
        int          rn, rmode, rrm, rlm, elat;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        seed = '0;
        range = '0;
        num_updates = '0;
        mode = '0;
        mem_ready = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        stray = 1'b0;
        pend = 0;
        abort_at = 0;
        rdy_mode = 1;
        lat_max = 1;
        repeat (3) @(negedge clk);
        check("reset_req", 64'(mem_req), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_cnt", 64'(upd_cnt), 64'd0);
        check("reset_err", 64'(err_unexp), 64'd0);
        check("reset_addr", mem_addr, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        clr();
        preload(64'h10, 64'h41);
        run(64'd0, '1, 1, 2'b00, 1, 1, 0, 0, 0, 1 * (STEPS + 3) + 1);
        check("t1_mem", mem[64'h10], 64'h42);
        check("t1_rd", 64'(rd_n), 64'd1);
        check("t1_wr", 64'(wr_n), 64'd1);

        clr();
        preload(64'h0, '1);
        run(64'd0, 64'hF, 1, 2'b00, 1, 1, 0, 0, 0, 1 * (STEPS + 3) + 1);
        check("t2_mem", mem[64'h0], 64'h0);

        clr();
        run({$urandom, $urandom}, '1, 2, 2'b01, 2, 2, 0, 0, 0, 0);
        check("t3_rd", 64'(rd_n), 64'd2);
        check("t3_wr", 64'(wr_n), 64'd2);

        clr();
        run({$urandom, $urandom}, '1, 3, 2'b10, 1, 1, 0, 0, 0,
            3 * (STEPS + 1) + 1);
        check("t4_rd", 64'(rd_n), 64'd0);
        check("t4_wr", 64'(wr_n), 64'd3);

        clr();
        run({$urandom, $urandom}, '1, 5, 2'b00, 0, 3, 2, 0, 0, 0);
        check("t5_rd", 64'(rd_n), 64'd2);
        check("t5_wr", 64'(wr_n), 64'd2);

        clr();
        run({$urandom, $urandom}, '1, 0, 2'b00, 1, 1, 0, 0, 0, -2);
        check("t6_noreq", 64'(rd_n + wr_n), 64'd0);

        clr();
        run({$urandom, $urandom}, 64'hFF, 2, 2'b11, 1, 1, 0, 1, 0,
            2 * (STEPS + 2) + 1);

        clr();
        run({$urandom, $urandom}, '1, 3, 2'b00, 2, 1, 0, 0, 1, 0);

        for (int i = 0; i < 12; i++) begin
            clr();
            rs = {$urandom, $urandom};
            rr = (i % 3 == 0) ? 64'hFF : ((i % 3 == 1) ? '1 : 64'h7);
            rn = $urandom_range(6, 1);
            rmode = $urandom_range(3, 0);
            rrm = $urandom_range(2, 0);
            rlm = $urandom_range(3, 1);
            elat = (rrm == 1 && rlm == 1 && rmode < 2)
                 ? rn * (STEPS + 3) + 1 : 0;
            run(rs, rr, rn, 2'(rmode), rrm, rlm, 0, 0, 0, elat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
